div_hilo_ctrl: RTL

Issue and writeback controller for integer division in the EX stage, upstream and downstream of the radix-2 divider. On a DIV/DIVU in EX it holds the pipeline, registers the operands, and launches the divider with a single-cycle request. It then captures the one-cycle result pulse into the architectural HI/LO registers and releases the pipeline. It also handles MTHI/MTLO writes, aborts a division in flight when an exception flush arrives, and resets the divider on that abort.

---
 rtl/div_hilo_ctrl_if.sv | 37 +++
 rtl/div_hilo_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/div_hilo_ctrl_if.sv
// Signal bundle between the EX-stage pipeline, the radix-2 divider and the
// HI/LO division controller. The controller uses the slave modport.
interface div_hilo_ctrl_if;
  logic        ex_div_valid;
  logic        ex_div_sign;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_mthi;
  logic        ex_mtlo;
  logic [31:0] ex_wdata;
  logic        flush;
  logic        stall_req;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic        div_opn_valid;
  logic        div_rst;
  logic        div_res_valid;
  logic        div_res_ready;
  logic [63:0] div_result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_div_valid, ex_div_sign, ex_rs, ex_rt, ex_mthi, ex_mtlo, ex_wdata,
    output flush, div_res_valid, div_result,
    input  stall_req, div_a, div_b, div_sign, div_opn_valid, div_rst,
    input  div_res_ready, hi, lo
  );

  modport slave (
    input  ex_div_valid, ex_div_sign, ex_rs, ex_rt, ex_mthi, ex_mtlo, ex_wdata,
    input  flush, div_res_valid, div_result,
    output stall_req, div_a, div_b, div_sign, div_opn_valid, div_rst,
    output div_res_ready, hi, lo
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// EX-stage issue/writeback controller for DIV/DIVU: launches the divider,
// captures its result into HI/LO, handles MTHI/MTLO and flush aborts.
module div_hilo_ctrl (
  input  logic            clk,
  input  logic            resetn,
  div_hilo_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic        r_div_sign;
  logic        r_opn_valid;
  logic        r_div_rst;
  logic        r_res_ready;

  logic w_div_go;
  logic w_move_ok;
  logic w_abort;

  assign w_div_go  = bus.ex_div_valid & ~bus.flush;
  assign w_move_ok = ~bus.ex_div_valid & ~bus.flush;
  assign w_abort   = bus.flush & ((r_state == ISSUE) | (r_state == WAIT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_hi        <= 32'd0;
      r_lo        <= 32'd0;
      r_div_a     <= 32'd0;
      r_div_b     <= 32'd0;
      r_div_sign  <= 1'b0;
      r_opn_valid <= 1'b0;
      r_div_rst   <= 1'b1;
      r_res_ready <= 1'b0;
    end else begin
      // Launch pulse and divider reset are single-cycle by construction.
      r_opn_valid <= 1'b0;
      r_div_rst   <= w_abort;
      case (r_state)
        IDLE: begin
          if (w_div_go) begin
            r_div_a     <= bus.ex_rs;
            r_div_b     <= bus.ex_rt;
            r_div_sign  <= bus.ex_div_sign;
            r_opn_valid <= 1'b1;
            r_state     <= ISSUE;
          end else if (w_move_ok) begin
            if (bus.ex_mthi) r_hi <= bus.ex_wdata;
            if (bus.ex_mtlo) r_lo <= bus.ex_wdata;
          end
        end
        ISSUE: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else begin
            r_state     <= WAIT;
            r_res_ready <= 1'b1;
          end
        end
        WAIT: begin
          // A result arriving with a flush belongs to a killed instruction.
          if (bus.flush) begin
            r_state     <= IDLE;
            r_res_ready <= 1'b0;
          end else if (bus.div_res_valid) begin
            r_hi        <= bus.div_result[63:32];
            r_lo        <= bus.div_result[31:0];
            r_state     <= DONE;
            r_res_ready <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.stall_req     = w_div_go & (r_state != DONE);
  assign bus.div_a         = r_div_a;
  assign bus.div_b         = r_div_b;
  assign bus.div_sign      = r_div_sign;
  assign bus.div_opn_valid = r_opn_valid;
  assign bus.div_rst       = r_div_rst;
  assign bus.div_res_ready = r_res_ready;
  assign bus.hi            = r_hi;
  assign bus.lo            = r_lo;

endmodule
